// File: rtl/kv_rle_expand.sv
// kv_rle_expand: expands a run-length-coded KV block (header beat followed by
// (value, run) symbols) into D-element rows of INT8 deltas on an AXI-Stream
// master, each row tagged with its block's FP16 scale. A fill-side row buffer
// feeds a single output register so one row can wait downstream while the
// next one is being built.
module kv_rle_expand #(
    parameter int D       = 128,
    parameter int LANES   = 8,
    parameter int IN_W    = 8,
    parameter int SCALE_W = 16,
    parameter int ROWS_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [IN_W*D-1:0]    m_axis_tdata,
    output logic [SCALE_W-1:0]   m_axis_tscale,
    output logic                 m_axis_tlast,
    output logic                 err_underrun,
    output logic                 err_overrun
);

    localparam int COL_W = $clog2(D + 1);
    localparam int RUN_W = 9;

    typedef enum logic [2:0] {
        S_HDR,
        S_SYM,
        S_RUN,
        S_DROP,
        S_PAD
    } state_t;

    state_t               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROWS_W-1:0]    rows_left_q, rows_left_d;
    logic [RUN_W-1:0]     run_left_q, run_left_d;
    logic [IN_W-1:0]      value_q, value_d;
    logic                 sym_last_q, sym_last_d;
    logic [SCALE_W-1:0]   scale_q, scale_d;
    logic [IN_W*D-1:0]    buf_q, buf_d;
    logic                 buf_last_q, buf_last_d;
    logic                 buf_under_q, buf_under_d;
    logic [SCALE_W-1:0]   buf_scale_q, buf_scale_d;
    logic                 out_valid_q, out_valid_d;
    logic [IN_W*D-1:0]    out_data_q, out_data_d;
    logic [SCALE_W-1:0]   out_scale_q, out_scale_d;
    logic                 out_last_q, out_last_d;
    logic                 err_under_q, err_under_d;
    logic                 err_over_q, err_over_d;

    logic                 s_ready;
    logic                 buf_full;
    logic                 out_free;
    logic                 xfer_old;
    logic                 xfer_new;
    logic                 can_write;
    logic [COL_W-1:0]     base_col;
    logic [IN_W*D-1:0]    base_data;
    logic [IN_W*D-1:0]    wr_data;
    logic [RUN_W-1:0]     room;
    logic [RUN_W-1:0]     n;
    logic [RUN_W-1:0]     run_after;
    logic [COL_W-1:0]     new_col;
    logic                 wr_en;
    logic                 fill_done;
    logic                 pad_fill;
    logic                 complete_now;
    logic                 is_final;
    logic                 new_last;
    logic                 new_under;

    // Block parser, run writer, row buffer and output register next-state logic.
    // A full row buffer is emptied into the output register the cycle it is
    // free; a row completing while the output register is free bypasses the
    // buffer so tvalid rises the cycle after its last element is written.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        rows_left_d  = rows_left_q;
        run_left_d   = run_left_q;
        value_d      = value_q;
        sym_last_d   = sym_last_q;
        scale_d      = scale_q;
        buf_d        = buf_q;
        buf_last_d   = buf_last_q;
        buf_under_d  = buf_under_q;
        buf_scale_d  = buf_scale_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_scale_d  = out_scale_q;
        out_last_d   = out_last_q;
        err_under_d  = 1'b0;
        err_over_d   = 1'b0;
        s_ready      = 1'b0;
        wr_en        = 1'b0;
        fill_done    = 1'b0;
        pad_fill     = 1'b0;
        new_last     = 1'b0;
        new_under    = 1'b0;

        buf_full  = (col_q == COL_W'(D));
        out_free  = !out_valid_q || m_axis_tready;
        xfer_old  = buf_full && out_free;
        can_write = !buf_full || xfer_old;
        base_col  = buf_full ? '0 : col_q;
        base_data = buf_full ? '0 : buf_q;
        is_final  = (rows_left_q == ROWS_W'(1));

        room = RUN_W'(D) - RUN_W'(base_col);
        n    = RUN_W'(LANES);
        if (run_left_q < n) n = run_left_q;
        if (room < n)       n = room;
        new_col   = base_col + COL_W'(n);
        run_after = run_left_q - n;

        case (state_q)
            S_HDR: begin
                s_ready = 1'b1;
                if (s_axis_tvalid) begin
                    scale_d     = s_axis_tdata[SCALE_W-1:0];
                    rows_left_d = s_axis_tdata[16 +: ROWS_W];
                    if (s_axis_tdata[16 +: ROWS_W] == '0)
                        state_d = s_axis_tlast ? S_HDR : S_DROP;
                    else if (s_axis_tlast)
                        state_d = S_PAD;
                    else
                        state_d = S_SYM;
                end
            end
            S_SYM: begin
                s_ready = !buf_full;
                if (s_ready && s_axis_tvalid) begin
                    run_left_d = RUN_W'(s_axis_tdata[15:8]) + RUN_W'(1);
                    value_d    = s_axis_tdata[IN_W-1:0];
                    sym_last_d = s_axis_tlast;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (can_write) begin
                    wr_en      = 1'b1;
                    run_left_d = run_after;
                    if (new_col == COL_W'(D)) begin
                        fill_done   = 1'b1;
                        rows_left_d = rows_left_q - ROWS_W'(1);
                        if (is_final) begin
                            new_last   = 1'b1;
                            run_left_d = '0;
                            if (run_after != '0 || !sym_last_q) begin
                                err_over_d = 1'b1;
                                state_d    = sym_last_q ? S_HDR : S_DROP;
                            end else begin
                                state_d = S_HDR;
                            end
                        end else if (run_after == '0) begin
                            state_d = sym_last_q ? S_PAD : S_SYM;
                        end
                    end else if (run_after == '0) begin
                        if (sym_last_q) begin
                            pad_fill  = 1'b1;
                            new_last  = 1'b1;
                            new_under = 1'b1;
                            state_d   = S_HDR;
                        end else begin
                            state_d = S_SYM;
                        end
                    end
                end
            end
            S_PAD: begin
                if (can_write) begin
                    pad_fill  = 1'b1;
                    new_last  = 1'b1;
                    new_under = 1'b1;
                    state_d   = S_HDR;
                end
            end
            S_DROP: begin
                s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase

        wr_data = base_data;
        if (wr_en) begin
            for (int i = 0; i < D; i++) begin
                if (i >= int'(base_col) && i < int'(new_col))
                    wr_data[i*IN_W +: IN_W] = value_q;
            end
        end

        complete_now = fill_done || pad_fill;
        xfer_new     = complete_now && !buf_full && out_free;

        if (xfer_new) begin
            buf_d = '0;
            col_d = '0;
        end else if (wr_en || pad_fill) begin
            buf_d = wr_data;
            col_d = complete_now ? COL_W'(D) : new_col;
            if (complete_now) begin
                buf_last_d  = new_last;
                buf_under_d = new_under;
                buf_scale_d = scale_q;
            end
        end else if (xfer_old) begin
            buf_d = '0;
            col_d = '0;
        end

        if (xfer_old) begin
            out_valid_d = 1'b1;
            out_data_d  = buf_q;
            out_scale_d = buf_scale_q;
            out_last_d  = buf_last_q;
            err_under_d = buf_under_q;
        end else if (xfer_new) begin
            out_valid_d = 1'b1;
            out_data_d  = wr_data;
            out_scale_d = scale_q;
            out_last_d  = new_last;
            err_under_d = new_under;
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR;
            col_q       <= '0;
            rows_left_q <= '0;
            run_left_q  <= '0;
            value_q     <= '0;
            sym_last_q  <= 1'b0;
            scale_q     <= '0;
            buf_q       <= '0;
            buf_last_q  <= 1'b0;
            buf_under_q <= 1'b0;
            buf_scale_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_scale_q <= '0;
            out_last_q  <= 1'b0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            rows_left_q <= rows_left_d;
            run_left_q  <= run_left_d;
            value_q     <= value_d;
            sym_last_q  <= sym_last_d;
            scale_q     <= scale_d;
            buf_q       <= buf_d;
            buf_last_q  <= buf_last_d;
            buf_under_q <= buf_under_d;
            buf_scale_q <= buf_scale_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_scale_q <= out_scale_d;
            out_last_q  <= out_last_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
        end
    end

    assign s_axis_tready = s_ready && !rst;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tscale = out_scale_q;
    assign m_axis_tlast  = out_last_q;
    assign err_underrun  = err_under_q;
    assign err_overrun   = err_over_q;

endmodule
